// File: rtl/audio_pkg.sv
// Shared definitions for the stereo PDM capture path: FSM encoding,
// PCM sample width and the gain saturation limits.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int PCM_W   = 16;
  localparam int FRAME_W = 2 * PCM_W;
  localparam int GAIN_W  = 23;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

endpackage

// File: rtl/audio_frame_fifo.sv
// DEPTH-entry synchronous frame FIFO with wrap-bit pointers. A push when full
// is accepted only if a pop happens in the same cycle.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FRAME_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is data-only; emptiness is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/audio_capture_ctrl.sv
// Capture sequencer: mic power-up, filter clear, warm-up frame discard,
// gain/saturation of each stereo frame and overflow accounting into the FIFO.
module audio_capture_ctrl
  import audio_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WARMUP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        stb_pcm,
  input  logic [15:0] pcm_left,
  input  logic [15:0] pcm_right,
  input  logic [2:0]  gain,
  input  logic        clr_ovf,
  output logic        mic_en,
  output logic        filt_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        running,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam logic signed [GAIN_W-1:0] SAT_HI = GAIN_W'(SAT_MAX);
  localparam logic signed [GAIN_W-1:0] SAT_LO = GAIN_W'(SAT_MIN);

  function automatic logic [PCM_W-1:0] gain_sat(input logic signed [PCM_W-1:0] x,
                                                input logic [2:0]              sh);
    logic signed [GAIN_W-1:0] ext;
    ext = {{(GAIN_W-PCM_W){x[PCM_W-1]}}, x};
    ext = ext <<< sh;
    if (ext > SAT_HI)      gain_sat = PCM_W'(SAT_MAX);
    else if (ext < SAT_LO) gain_sat = PCM_W'(SAT_MIN);
    else                   gain_sat = ext[PCM_W-1:0];
  endfunction

  state_t                   state;
  state_t                   state_nxt;
  logic [7:0]               warm_cnt;
  logic                     vld_p0;
  logic signed [PCM_W-1:0]  left_s;
  logic signed [PCM_W-1:0]  right_s;
  logic [FRAME_W-1:0]       frame_p0;
  logic [FRAME_W-1:0]       head;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic                     full;
  logic                     empty;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mic_en    = 1'b0;
    filt_clr  = 1'b0;
    running   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        mic_en    = 1'b1;
        filt_clr  = 1'b1;
        state_nxt = ST_WARMUP;
      end
      ST_WARMUP: begin
        mic_en = 1'b1;
        if (stb_pcm && (warm_cnt == 8'd1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        mic_en  = 1'b1;
        running = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  // Strobes seen in CLEAR are not counted; the load happens on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n)                           warm_cnt <= '0;
    else if (state == ST_CLEAR)           warm_cnt <= 8'(WARMUP);
    else if (state == ST_WARMUP && stb_pcm) warm_cnt <= warm_cnt - 8'd1;
  end

  // ---- stage p0: filters update on stb_pcm, sample one cycle later ----
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= (state == ST_RUN) && stb_pcm && enable;
  end

  assign left_s   = pcm_left;
  assign right_s  = pcm_right;
  assign frame_p0 = {gain_sat(left_s, gain), gain_sat(right_s, gain)};

  // A disable in the capture cycle cancels the pending frame.
  assign push = vld_p0 && enable && (state == ST_RUN);
  assign pop  = !empty && out_ready;
  assign drop = push && full && !pop;

  audio_frame_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (frame_p0),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head;

  // A drop in the same cycle as clr_ovf wins and restarts the count at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
